// File: rtl/multi_debounce.sv
// multi_debounce: CH-channel switch debouncer.
// Each channel is synchronised through two flops, then accepted as a new
// level only after it has differed from the current output for STABLE
// consecutive enabled cycles. Every accepted change produces a one-cycle
// rise or fall pulse, and any_evt is the OR of all pulses in that cycle.
`timescale 1ns/1ps

module multi_debounce #(
    parameter int CH     = 4,
    parameter int STABLE = 4,
    parameter bit INIT   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          any_evt
);

    // A single-cycle filter still needs a 1-bit counter so the vector is legal.
    localparam int            CW   = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

    logic [CH-1:0]         s1;
    logic [CH-1:0]         s2;
    logic [CH-1:0][CW-1:0] cnt;
    logic [CH-1:0][CW-1:0] cnt_nxt;
    logic [CH-1:0]         out_nxt;
    logic [CH-1:0]         rise_nxt;
    logic [CH-1:0]         fall_nxt;

    // Per-channel acceptance rule; with en low everything holds and no pulse is produced.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block can leave a value unassigned and infer a latch.
        cnt_nxt  = cnt;
        out_nxt  = out;
        rise_nxt = '0;
        fall_nxt = '0;
        if (en) begin
            for (int i = 0; i < CH; i++) begin
                if (s2[i] == out[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == LAST) begin
                    cnt_nxt[i]  = '0;
                    out_nxt[i]  = s2[i];
                    rise_nxt[i] = s2[i];
                    fall_nxt[i] = ~s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // State update: synchronisers always run; reset overrides en and any partial count.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here, so s2 samples the old s1 and
        // every register sees pre-edge values regardless of statement order.
        if (rst) begin
            s1      <= {CH{INIT}};
            s2      <= {CH{INIT}};
            cnt     <= '0;
            out     <= {CH{INIT}};
            rise    <= '0;
            fall    <= '0;
            any_evt <= 1'b0;
        end else begin
            s1      <= sw;
            s2      <= s1;
            cnt     <= cnt_nxt;
            out     <= out_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            any_evt <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: directed test of multi_debounce with default parameters
// (CH=4, STABLE=4, INIT=0) plus a second STABLE=1 instance.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
`timescale 1ns/1ps

module tb_multi_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] sw;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_evt;

    logic [3:0] sw1;
    logic [3:0] out1;
    logic [3:0] rise1;
    logic [3:0] fall1;
    logic       evt1;

    int checks   = 0;
    int failures = 0;

    // pulse counters for the STABLE=4 instance, accumulated every cycle
    int rise_n [4];
    int fall_n [4];
    int evt_n;

    always #5 clk = ~clk;

    multi_debounce #(.CH(4), .STABLE(4), .INIT(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sw      (sw),
        .out     (out),
        .rise    (rise),
        .fall    (fall),
        .any_evt (any_evt)
    );

    multi_debounce #(.CH(4), .STABLE(1), .INIT(1'b0)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sw      (sw1),
        .out     (out1),
        .rise    (rise1),
        .fall    (fall1),
        .any_evt (evt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            rise_n[i] = 0;
            fall_n[i] = 0;
        end
        evt_n = 0;
    endtask

    // advance n rising edges; sample 1 ns after each and accumulate pulses
    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                rise_n[i] += int'(rise[i]);
                fall_n[i] += int'(fall[i]);
            end
            evt_n += int'(any_evt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        sw  = 4'hF;
        sw1 = 4'h0;
        clear_counts();

        // ---- reset with all inputs high ----
        cyc(1);
        check("rst_out_c1", 32'(out), 32'h0);
        check("rst_evt_c1", 32'({rise, fall, any_evt}), 32'h0);
        cyc(1);
        check("rst_out_c2", 32'(out), 32'h0);
        check("rst_evt_c2", 32'({rise, fall, any_evt}), 32'h0);
        check("rst_out1", 32'(out1), 32'h0);
        rst = 1'b0;
        cyc(5);
        check("rel_out_5", 32'(out), 32'h0);
        cyc(1);
        check("rel_out_6", 32'(out), 32'hF);
        check("rel_rise_6", 32'(rise), 32'hF);
        check("rel_fall_6", 32'(fall), 32'h0);
        check("rel_evt_6", 32'(any_evt), 32'h1);
        cyc(1);
        check("rel_rise_7", 32'({rise, any_evt}), 32'h0);
        check("rel_out_7", 32'(out), 32'hF);

        // ---- press bounce on channel 0 ----
        sw = 4'h0;
        do_reset();
        clear_counts();
        cyc(10);
        for (int t = 0; t < 10; t++) begin
            sw[0] = ~sw[0];       // 1,0,1,...,0
            cyc(1);
        end
        check("bnc_out_toggle", 32'(out[0]), 32'h0);
        sw[0] = 1'b1;             // last 0->1 change
        cyc(5);
        check("bnc_out_5", 32'(out[0]), 32'h0);
        check("bnc_rise_none", 32'(rise_n[0]), 32'h0);
        cyc(1);
        check("bnc_out_6", 32'(out[0]), 32'h1);
        check("bnc_rise_6", 32'(rise[0]), 32'h1);
        cyc(4);
        check("bnc_rise_cnt", 32'(rise_n[0]), 32'h1);
        check("bnc_fall_cnt", 32'(fall_n[0]), 32'h0);

        // ---- release bounce on channel 0 ----
        clear_counts();
        for (int t = 0; t < 10; t++) begin
            sw[0] = ~sw[0];       // 0,1,0,...,1
            cyc(1);
        end
        check("rel_bnc_out", 32'(out[0]), 32'h1);
        sw[0] = 1'b0;             // final 1->0 change
        cyc(5);
        check("rbn_out_5", 32'(out[0]), 32'h1);
        cyc(1);
        check("rbn_out_6", 32'(out[0]), 32'h0);
        check("rbn_fall_6", 32'(fall[0]), 32'h1);
        cyc(3);
        check("rbn_fall_cnt", 32'(fall_n[0]), 32'h1);
        check("rbn_rise_cnt", 32'(rise_n[0]), 32'h0);

        // ---- independence and simultaneity ----
        sw = 4'h0;
        do_reset();
        clear_counts();
        sw = 4'b0101;
        cyc(1);
        sw = 4'b0111;             // channel 1 glitch, 2 cycles
        cyc(2);
        sw = 4'b0101;
        cyc(2);
        check("ind_out_5", 32'(out), 32'h0);
        cyc(1);
        check("ind_out_6", 32'(out), 32'h5);
        check("ind_rise_6", 32'(rise), 32'h5);
        check("ind_evt_6", 32'(any_evt), 32'h1);
        cyc(5);
        check("ind_evt_cnt", 32'(evt_n), 32'h1);
        check("ind_out_end", 32'(out), 32'h5);
        check("ind_ch1_rise", 32'(rise_n[1]), 32'h0);

        // ---- enable freeze on channel 2 ----
        sw = 4'h0;
        do_reset();
        clear_counts();
        sw[2] = 1'b1;
        cyc(4);                   // cnt[2] = 2 after this
        en = 1'b0;
        cyc(5);
        check("frz_out", 32'(out[2]), 32'h0);
        check("frz_evt_cnt", 32'(evt_n), 32'h0);
        check("frz_rise_cnt", 32'(rise_n[2]), 32'h0);
        en = 1'b1;
        cyc(1);
        check("frz_out_r1", 32'(out[2]), 32'h0);
        cyc(1);
        check("frz_out_r2", 32'(out[2]), 32'h1);
        check("frz_rise_r2", 32'(rise[2]), 32'h1);

        // ---- reset mid-count on channel 3 ----
        sw = 4'h0;
        do_reset();
        clear_counts();
        sw[3] = 1'b1;
        cyc(4);                   // cnt[3] = 2 = STABLE-2
        rst = 1'b1;
        cyc(1);
        check("mid_rst_out", 32'(out), 32'h0);
        check("mid_rst_evt", 32'({rise, fall, any_evt}), 32'h0);
        rst = 1'b0;
        cyc(5);
        check("mid_out_5", 32'(out[3]), 32'h0);
        check("mid_evt_cnt", 32'(evt_n), 32'h0);
        cyc(1);
        check("mid_out_6", 32'(out[3]), 32'h1);
        check("mid_rise_6", 32'(rise[3]), 32'h1);

        // ---- STABLE=1 instance: 2-cycle pulse on channel 0 ----
        sw1[0] = 1'b1;
        cyc(2);
        check("s1_out_2", 32'(out1[0]), 32'h0);
        sw1[0] = 1'b0;
        cyc(1);
        check("s1_out_3", 32'(out1[0]), 32'h1);
        check("s1_rise_3", 32'(rise1), 32'h1);
        check("s1_evt_3", 32'(evt1), 32'h1);
        cyc(1);
        check("s1_out_4", 32'(out1[0]), 32'h1);
        check("s1_pulse_4", 32'({rise1, fall1}), 32'h0);
        cyc(1);
        check("s1_out_5", 32'(out1[0]), 32'h0);
        check("s1_fall_5", 32'(fall1), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_debounce.md
# multi_debounce

Parametrised, multi-channel successor to the single-switch debouncer. It synchronises CH asynchronous switch/button inputs into the clk domain and filters each channel independently. A channel's output changes only after its input has held the new level for STABLE consecutive cycles. On every accepted change it emits one-cycle rise/fall pulses, so downstream logic gets clean levels and edge events without its own edge detectors.

## Interface
- CH, default 4: number of independent channels (≥1).
- STABLE, default 4: consecutive stable cycles required to accept a new level (≥1).
- INIT, default 0: reset level of synchroniser stages and debounced output, all channels (1-bit, replicated).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset; sampled on clk rising edge.
- en  input  1  filter enable; low freezes counters, outputs and pulses (synchronisers keep running).
- sw  input  CH  raw asynchronous inputs, bit i = channel i.
- out  output  CH  debounced level per channel.
- rise  output  CH  one-cycle pulse when out[i] goes 0→1.
- fall  output  CH  one-cycle pulse when out[i] goes 1→0.
- any_evt  output  1  registered OR of all rise|fall bits, coincident with them.

## Operation
- Per channel: 2-flop synchroniser s1 <= sw[i], s2 <= s1; counter cnt of width max(1,$clog2(STABLE)).
- Per channel, each edge with en=1:
  - s2 == out[i]: cnt <= 0.
  - s2 != out[i] and cnt == STABLE-1: out[i] <= s2, cnt <= 0, rise[i] or fall[i] <= 1 per direction.
  - otherwise: cnt <= cnt+1.
- Any cycle where s2 returns to out[i] restarts the count. Bounce shorter than STABLE cycles never reaches out.
- rise/fall default 0 every cycle unless set by the acceptance rule above. rise[i] and fall[i] are never both 1.
- en=0: cnt, out, hold. rise, fall, any_evt are 0. s1/s2 continue sampling. When en returns to 1, evaluation resumes from the held cnt.
- Channels are fully independent. Simultaneous acceptances on several channels each pulse in the same cycle; any_evt is a single 1.
- cnt never exceeds STABLE-1. No wrap-around is possible.

## Timing
- Reset (rst=1 at an edge): s1, s2, out = {CH{INIT}}; cnt = 0; rise, fall, any_evt = 0.
  - Reset takes priority over en and over any in-progress count.
  - Reset asserted mid-count discards the count. No pulse is emitted on reset or on reset release.
- Latency: sw[i] changes and is stable before edge k. Then s2 updates at edge k+1 and out[i] updates at edge k+STABLE+1, i.e. STABLE+2 edges including k.
  - STABLE=4: out changes 6 cycles after the input setup edge.
  - STABLE=1: out changes at edge k+2.
- rise/fall/any_evt assert in the same cycle out changes and deassert on the next edge.
- Input toggling every cycle with STABLE≥2: out never changes.

## Test plan
- Reset: CH=4, INIT=0, rst=1 for 2 cycles with sw=4'hF. Required: out=0, rise=fall=0, any_evt=0 during reset. After release, out[3:0]=F exactly 6 cycles later (STABLE=4), with rise=4'hF and any_evt=1 for one cycle.
- Bounce rejection: sw[0] 0 for 10 cycles, then toggles 0/1 every cycle for 10 cycles, then 1 for 10 cycles. Required: out[0] stays 0 through the toggling, rises exactly STABLE+2 edges after the last 0→1 change, single rise[0] pulse, fall[0] never set.
- Release bounce: from out[0]=1, sw[0] toggles 1/0 for 10 cycles then holds 0. Required: exactly one fall[0] pulse, STABLE+2 edges after the final 1→0 change; no rise pulses.
- Independence and simultaneity: sw=4'b0101 applied at once, then sw[1] glitches high for 2 cycles. Required: out=4'b0101 with rise=4'b0101 in one cycle and any_evt=1 once; out[1] stays 0.
- Enable freeze: sw[2] goes 1, en dropped after 2 counted cycles for 5 cycles, then restored. Required: out[2] stays 0 while en=0, no pulses while en=0. out[2] rises STABLE-2 edges after en returns high.
- Reset mid-count and STABLE=1 build: rst pulsed while cnt=STABLE-2 leaves out=INIT with no pulse, and the count restarts from 0. With STABLE=1, a single-cycle sw pulse longer than 1 cycle propagates to out at edge k+2.
